sisc_ctrl_exec: RTL and testbench

Combined control/execute unit of the SISC processor: multi-cycle control FSM, 32-bit ALU with condition codes, and branch-address adder. Sits between instruction memory (IR), register file, status register, PC, data memory and write-back muxes.
Sub-functions stay separable as ctrl, alu and br logic inside one block.

---
 rtl/sisc_pkg.sv | 49 ++++
 rtl/sisc_alu_core.sv | 60 ++++++
 rtl/sisc_ctrl_exec.sv | 151 +++++++++++++++
 tb/tb_sisc_ctrl_exec.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC control/execute unit: opcodes, ALU functions,
// FSM state codes and condition-code bit positions.
package sisc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_SWAP   = 4'h3;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_BRR    = 4'h5;
    localparam logic [3:0] OP_BNE    = 4'h6;
    localparam logic [3:0] OP_BNR    = 4'h7;
    localparam logic [3:0] OP_LOD    = 4'h8;
    localparam logic [3:0] OP_STR    = 4'h9;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_AND  = 4'h2;
    localparam logic [3:0] FN_OR   = 4'h3;
    localparam logic [3:0] FN_XOR  = 4'h4;
    localparam logic [3:0] FN_NOT  = 4'h5;
    localparam logic [3:0] FN_SHL  = 4'h6;
    localparam logic [3:0] FN_SHR  = 4'h7;
    localparam logic [3:0] FN_ROTL = 4'h8;
    localparam logic [3:0] FN_ROTR = 4'h9;

    localparam logic [2:0] ST_START0  = 3'd0;
    localparam logic [2:0] ST_START1  = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_DECODE  = 3'd3;
    localparam logic [2:0] ST_EXECUTE = 3'd4;
    localparam logic [2:0] ST_MEM     = 3'd5;
    localparam logic [2:0] ST_WB      = 3'd6;
    localparam logic [2:0] ST_HALT    = 3'd7;

    localparam int unsigned CC_C = 3;
    localparam int unsigned CC_V = 2;
    localparam int unsigned CC_N = 1;
    localparam int unsigned CC_Z = 0;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [ADDR_W-1:0] imm);
        return {{(DATA_W-ADDR_W){imm[ADDR_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/sisc_alu_core.sv
// Combinational 32-bit ALU producing the result and new {C,V,N,Z} flags.
module sisc_alu_core
    import sisc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        fn,
    output logic [DATA_W-1:0] result_c,
    output logic [3:0]        cc_c
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [4:0]        sh;
    logic [5:0]        sh_inv;
    logic              carry;
    logic              ovf;

    assign sh     = b[4:0];
    assign sh_inv = 6'd32 - {1'b0, sh};
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};

    // Carry/overflow only meaningful for ADD/SUB; every other function clears them.
    always_comb begin
        result_c = a;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (fn)
            FN_ADD: begin
                result_c = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                ovf      = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            FN_SUB: begin
                result_c = diff[DATA_W-1:0];
                carry    = ~diff[DATA_W];
                ovf      = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            FN_AND:  result_c = a & b;
            FN_OR:   result_c = a | b;
            FN_XOR:  result_c = a ^ b;
            FN_NOT:  result_c = ~a;
            FN_SHL:  result_c = a << sh;
            FN_SHR:  result_c = a >> sh;
            FN_ROTL: result_c = (a << sh) | (a >> sh_inv);
            FN_ROTR: result_c = (a >> sh) | (a << sh_inv);
            default: result_c = a;
        endcase
    end

    always_comb begin
        cc_c       = 4'b0000;
        cc_c[CC_C] = carry;
        cc_c[CC_V] = ovf;
        cc_c[CC_N] = result_c[DATA_W-1];
        cc_c[CC_Z] = (result_c == '0);
    end

endmodule

// File: rtl/sisc_ctrl_exec.sv
// SISC control/execute unit: multi-cycle control FSM, ALU with condition codes
// and branch-target adder.
module sisc_ctrl_exec
    import sisc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_F,
    input  logic [31:0]       ir,
    input  logic [3:0]        stat,
    input  logic [31:0]       rsa,
    input  logic [31:0]       rsb,
    input  logic [15:0]       pc_inc,
    output logic [31:0]       alu_result,
    output logic [3:0]        cc,
    output logic              cc_en,
    output logic [15:0]       br_addr,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              pc_sel,
    output logic              pc_write,
    output logic              pc_rst,
    output logic              br_sel,
    output logic              mm_sel,
    output logic              dm_we,
    output logic [1:0]        rd_sel,
    output logic              swap_mux,
    output logic              swap_data,
    output logic              swap_reg
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [3:0]        op;
    logic [3:0]        mm;
    logic [ADDR_W-1:0] imm;
    logic              is_alu;
    logic              is_mem;
    logic              is_branch;
    logic              br_abs;
    logic              br_taken;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_fn;
    logic              unused_ir_regs;

    assign op   = ir[31:28];
    assign mm   = ir[27:24];
    assign imm  = ir[15:0];
    // Register specifiers are consumed by the register file, not here.
    assign unused_ir_regs = ^ir[23:16];

    assign is_alu    = (op == OP_ALU_RR) || (op == OP_ALU_RI);
    assign is_mem    = (op == OP_LOD) || (op == OP_STR);
    assign is_branch = (op == OP_BRA) || (op == OP_BRR) || (op == OP_BNE) || (op == OP_BNR);
    assign br_abs    = (op == OP_BRA) || (op == OP_BNE);
    assign br_taken  = ((op == OP_BRA) || (op == OP_BRR)) ? ((stat & mm) != 4'b0000)
                                                          : ((stat & mm) == 4'b0000);

    // Memory ops reuse the adder for base+offset addressing.
    assign alu_b  = (op == OP_ALU_RI || is_mem) ? sext_imm(imm) : rsb;
    assign alu_fn = is_mem ? FN_ADD : mm;

    sisc_alu_core u_alu (
        .a        (rsa),
        .b        (alu_b),
        .fn       (alu_fn),
        .result_c (alu_result),
        .cc_c     (cc)
    );

    assign br_addr = br_sel ? imm : ADDR_W'(pc_inc + imm);

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) state <= ST_START0;
        else        state <= state_nxt;
    end

    // Next state and per-state datapath controls.
    always_comb begin
        state_nxt = state;
        pc_rst    = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        br_sel    = 1'b0;
        cc_en     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        mm_sel    = 1'b0;
        dm_we     = 1'b0;
        rd_sel    = 2'b00;
        swap_mux  = 1'b0;
        swap_data = 1'b0;
        swap_reg  = 1'b0;
        case (state)
            ST_START0: begin
                pc_rst    = 1'b1;
                state_nxt = ST_START1;
            end
            ST_START1: state_nxt = ST_FETCH;
            ST_FETCH: begin
                pc_write  = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                state_nxt = (op == OP_HLT) ? ST_HALT : ST_EXECUTE;
                if (is_branch) begin
                    br_sel   = br_abs;
                    pc_sel   = br_taken;
                    pc_write = br_taken;
                end
            end
            ST_EXECUTE: begin
                state_nxt = ST_MEM;
                cc_en     = is_alu;
                mm_sel    = is_mem && !mm[0];
            end
            ST_MEM: begin
                state_nxt = ST_WB;
                mm_sel    = is_mem && !mm[0];
                dm_we     = (op == OP_STR);
                if (op == OP_LOD) begin
                    wb_sel = 1'b1;
                    rd_sel = 2'b01;
                end
                if (op == OP_SWAP) begin
                    swap_mux  = 1'b1;
                    rd_sel    = 2'b10;
                    rf_we     = 1'b1;
                    swap_data = 1'b1;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                if (op == OP_LOD) begin
                    wb_sel = 1'b1;
                    rd_sel = 2'b01;
                    rf_we  = 1'b1;
                end
                if (is_alu) rf_we = 1'b1;
                if (op == OP_SWAP) begin
                    swap_mux = 1'b1;
                    rd_sel   = 2'b10;
                    rf_we    = 1'b1;
                    swap_reg = 1'b1;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_START0;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_exec.sv
// Scoreboard bench for sisc_ctrl_exec: a reference model queues the expected
// control events per instruction, a monitor pops and compares on every active cycle.
module tb_sisc_ctrl_exec;

    logic        CLK = 1'b0;
    logic        RST_F = 1'b0;
    logic [31:0] ir = '0;
    logic [3:0]  stat = '0;
    logic [31:0] rsa = '0;
    logic [31:0] rsb = '0;
    logic [15:0] pc_inc = '0;
    logic [31:0] alu_result;
    logic [3:0]  cc;
    logic        cc_en;
    logic [15:0] br_addr;
    logic        rf_we, wb_sel, pc_sel, pc_write, pc_rst, br_sel, mm_sel, dm_we;
    logic [1:0]  rd_sel;
    logic        swap_mux, swap_data, swap_reg;

    sisc_ctrl_exec dut (
        .CLK(CLK), .RST_F(RST_F), .ir(ir), .stat(stat), .rsa(rsa), .rsb(rsb),
        .pc_inc(pc_inc), .alu_result(alu_result), .cc(cc), .cc_en(cc_en),
        .br_addr(br_addr), .rf_we(rf_we), .wb_sel(wb_sel), .pc_sel(pc_sel),
        .pc_write(pc_write), .pc_rst(pc_rst), .br_sel(br_sel), .mm_sel(mm_sel),
        .dm_we(dm_we), .rd_sel(rd_sel), .swap_mux(swap_mux),
        .swap_data(swap_data), .swap_reg(swap_reg)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pc_rst, pc_write, pc_sel, br_sel, cc_en, rf_we;
        logic        wb_sel, dm_we, mm_sel, swap_mux, swap_data, swap_reg;
        logic [1:0]  rd_sel;
        logic [3:0]  cc;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [13:0] ctl_vec();
        return {pc_rst, pc_write, pc_sel, br_sel, cc_en, rf_we,
                wb_sel, dm_we, mm_sel, swap_mux, swap_data, swap_reg, rd_sel};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference ALU written from the function table with wide arithmetic.
    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fn,
                           output logic [31:0] r, output logic [3:0] f);
        longint unsigned ua, ub;
        longint sa, sb, sr;
        logic c, v;
        int s;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b[4:0]);
        c  = 1'b0;
        v  = 1'b0;
        r  = a;
        case (fn)
            4'h0: begin
                r  = a + b;
                c  = (ua + ub) >= 64'h1_0000_0000;
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h1: begin
                r  = a - b;
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: r = a << s;
            4'h7: r = a >> s;
            4'h8: for (int k = 0; k < s; k++) r = {r[30:0], r[31]};
            4'h9: for (int k = 0; k < s; k++) r = {r[0], r[31:1]};
            default: r = a;
        endcase
        f = {c, v, r[31], (r == 32'h0)};
    endtask

    // Queue every cycle's expected non-idle control pattern for one instruction.
    task automatic model_instr(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] st, input logic [15:0] pci);
        logic [3:0]  op, mm;
        logic [15:0] imm;
        logic [31:0] simm, res;
        logic [3:0]  f;
        logic        taken, absb;
        ev_t e;
        op   = i[31:28];
        mm   = i[27:24];
        imm  = i[15:0];
        simm = {{16{imm[15]}}, imm};
        e = '0; e.pc_write = 1'b1; exp_q.push_back(e);
        if (op inside {4'h4, 4'h5, 4'h6, 4'h7}) begin
            taken = (op == 4'h4 || op == 4'h5) ? ((st & mm) != 0) : ((st & mm) == 0);
            absb  = (op == 4'h4 || op == 4'h6);
            if (taken || absb) begin
                e = '0;
                e.pc_write = taken;
                e.pc_sel   = taken;
                e.br_sel   = absb;
                e.data     = absb ? {16'h0, imm} : 32'((int'(pci) + int'(imm)) % 65536);
                exp_q.push_back(e);
            end
        end
        if (op == 4'hF) return;
        res = '0;
        if (op == 4'h1 || op == 4'h2) begin
            ref_alu(a, (op == 4'h1) ? b : simm, mm, res, f);
            e = '0; e.cc_en = 1'b1; e.cc = f; e.data = res; exp_q.push_back(e);
        end
        if ((op == 4'h8 || op == 4'h9) && !mm[0]) begin
            e = '0; e.mm_sel = 1'b1; exp_q.push_back(e);
        end
        if (op == 4'h9) begin
            e = '0; e.dm_we = 1'b1; e.mm_sel = !mm[0]; e.data = mm[0] ? a + simm : 32'h0;
            exp_q.push_back(e);
        end
        if (op == 4'h8) begin
            e = '0; e.wb_sel = 1'b1; e.rd_sel = 2'b01; e.mm_sel = !mm[0]; exp_q.push_back(e);
            e = '0; e.wb_sel = 1'b1; e.rd_sel = 2'b01; e.rf_we = 1'b1; exp_q.push_back(e);
        end
        if (op == 4'h3) begin
            e = '0; e.swap_mux = 1'b1; e.rd_sel = 2'b10; e.rf_we = 1'b1; e.swap_data = 1'b1;
            exp_q.push_back(e);
            e = '0; e.swap_mux = 1'b1; e.rd_sel = 2'b10; e.rf_we = 1'b1; e.swap_reg = 1'b1;
            exp_q.push_back(e);
        end
        if (op == 4'h1 || op == 4'h2) begin
            e = '0; e.rf_we = 1'b1; e.data = res; exp_q.push_back(e);
        end
    endtask

    // Monitor: any cycle with a non-idle control output must match the queue head.
    always @(negedge CLK) begin
        ev_t o, w;
        if (RST_F && ctl_vec() != 14'h0) begin
            o = '0;
            {o.pc_rst, o.pc_write, o.pc_sel, o.br_sel, o.cc_en, o.rf_we, o.wb_sel,
             o.dm_we, o.mm_sel, o.swap_mux, o.swap_data, o.swap_reg, o.rd_sel} = ctl_vec();
            if (br_sel || pc_sel)                o.data = {16'h0, br_addr};
            else if (cc_en)                      o.data = alu_result;
            else if (dm_we && !mm_sel)           o.data = alu_result;
            else if (rf_we && !wb_sel && !swap_mux) o.data = alu_result;
            o.cc = cc_en ? cc : 4'h0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", o);
            end else begin
                w = exp_q.pop_front();
                if (o !== w) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", o, w);
                end
            end
        end
    end

    task automatic do_reset();
        ev_t e;
        RST_F = 1'b0;
        #1;
        check("reset_state", {18'h0, ctl_vec()}, 32'h0000_2000);
        repeat (2) @(posedge CLK);
        #1;
        RST_F = 1'b1;
        e = '0; e.pc_rst = 1'b1; exp_q.push_back(e);
        repeat (2) @(posedge CLK);
        #1;
        check("first_fetch", {18'h0, ctl_vec()}, 32'h0000_1000);
    endtask

    // Called at FETCH+1: apply operands and hold them through WRITEBACK.
    task automatic run_instr(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] st, input logic [15:0] pci);
        ir = i; rsa = a; rsb = b; stat = st; pc_inc = pci;
        model_instr(i, a, b, st, pci);
        repeat (5) @(posedge CLK);
        #1;
    endtask

    initial begin
        do_reset();
        run_instr(32'h1023_1000, 32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 16'h0001);
        run_instr(32'h4400_0010, 32'h0, 32'h0, 4'b0100, 16'h0002);
        run_instr(32'h4400_0010, 32'h0, 32'h0, 4'b0000, 16'h0003);
        run_instr(32'h7100_FFFE, 32'h0, 32'h0, 4'b0000, 16'h0005);
        run_instr(32'h9100_0004, 32'h0000_0100, 32'h0, 4'h0, 16'h0006);
        run_instr(32'h8000_0020, 32'h0000_0100, 32'h0, 4'h0, 16'h0007);
        run_instr(32'h3012_0000, 32'hAAAA_0000, 32'h0000_5555, 4'h0, 16'h0008);
        run_instr(32'h1123_0000, 32'h0000_0001, 32'h0000_0002, 4'h0, 16'h0009);
        run_instr(32'h2800_0004, 32'h8000_0001, 32'h0, 4'h0, 16'h000A);
        run_instr(32'h2900_0024, 32'h8000_0001, 32'h0, 4'h0, 16'h000B);
        run_instr(32'h5200_0100, 32'h0, 32'h0, 4'b0010, 16'hFF80);
        run_instr(32'h6100_1234, 32'h0, 32'h0, 4'b0001, 16'h0000);

        for (int n = 0; n < 80; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            run_instr({op, 28'($urandom)}, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      16'($urandom));
        end

        // Abort a SWAP in EXECUTE: nothing beyond its FETCH may appear.
        ir = 32'h3045_0000; rsa = 32'h1; rsb = 32'h2;
        begin
            ev_t e;
            e = '0; e.pc_write = 1'b1; exp_q.push_back(e);
        end
        repeat (2) @(posedge CLK);
        #1;
        do_reset();
        run_instr(32'h1423_0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h0, 16'h0010);

        // HLT freezes the machine until reset.
        ir = 32'hF000_0000;
        model_instr(ir, 32'h0, 32'h0, 4'h0, 16'h0);
        repeat (15) @(posedge CLK);
        #1;
        check("halt_idle", {18'h0, ctl_vec()}, 32'h0);
        do_reset();
        run_instr(32'h2000_FFFF, 32'h0000_0001, 32'h0, 4'h0, 16'h0011);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
